// File: rtl/sign_line_buffer.sv
// Three-bank sign-row line buffer emitting zero-padded 3x3 binary windows, channel-major, column-minor.
// Define PAD_ONE_EN to make every out-of-range window position read as 1 instead of 0.
module sign_line_buffer #(
    parameter int ROW_LEN = 10,
    parameter int CH      = 64
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [ROW_LEN-1:0] row_in,
    input  logic               row_valid_in,
    output logic               row_ready_out,
    input  logic               row_sof_in,
    input  logic               row_eof_in,
    output logic [8:0]         win_out,
    output logic               win_valid_out,
    input  logic               win_ready_in,
    output logic               win_last_out,
    output logic               win_eof_out
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int XW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
`ifdef PAD_ONE_EN
    localparam logic PAD = 1'b1;
`else
    localparam logic PAD = 1'b0;
`endif

    typedef enum logic [1:0] {S_FILL, S_EMIT, S_FLUSH} state_t;

    state_t             r_state, w_state_nx;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_ptr, r_rows;
    logic               r_eof_pend, w_eof_pend_nx;
    logic [1:0]         r_top_bank, r_ctr_bank, r_bot_bank;
    logic [1:0]         w_top_bank_nx, w_ctr_bank_nx, w_bot_bank_nx;
    logic               r_top_ok, r_bot_ok, w_top_ok_nx, w_bot_ok_nx;
    logic [CW-1:0]      r_ech, w_ech_nx;
    logic [XW-1:0]      r_ecol, w_ecol_nx;
    logic [8:0]         r_win;
    logic               r_valid, r_last, r_eof;
    logic               w_load;
    logic [ROW_LEN-1:0] r_mem [3][CH];

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [1:0] dec3(input logic [1:0] p);
        return (p == 2'd0) ? 2'd2 : p - 2'd1;
    endfunction

    // Cols x-1, x, x+1 of a row with a pad bit on either side; a missing row is all pad.
    function automatic logic [2:0] triplet(input logic [ROW_LEN-1:0] row, input logic ok,
                                           input logic [XW-1:0] col);
        logic [ROW_LEN+1:0] ext;
        ext = ok ? {PAD, row, PAD} : {(ROW_LEN+2){PAD}};
        return 3'(ext >> (XW'(ROW_LEN-1) - col));
    endfunction

    logic [CW-1:0] w_idx;
    logic [1:0]    w_rows_prev, w_rows_now;
    logic          w_beat, w_row_done, w_hs, w_ph_last, w_last_nx;
    logic [8:0]    w_win;

    assign row_ready_out = (r_state == S_FILL);
    assign w_beat        = row_valid_in & row_ready_out;
    assign w_idx         = row_sof_in ? '0 : r_cnt;
    assign w_row_done    = w_beat && (w_idx == CW'(CH-1));
    assign w_rows_prev   = row_sof_in ? 2'd0 : r_rows;
    assign w_rows_now    = (w_rows_prev == 2'd2) ? 2'd2 : w_rows_prev + 2'd1;
    assign w_hs          = r_valid & win_ready_in;
    assign w_ph_last     = (r_ech == CW'(CH-1)) && (r_ecol == XW'(ROW_LEN-1));

    always_comb begin
        w_state_nx    = r_state;
        w_ech_nx      = r_ech;
        w_ecol_nx     = r_ecol;
        w_top_bank_nx = r_top_bank;
        w_ctr_bank_nx = r_ctr_bank;
        w_bot_bank_nx = r_bot_bank;
        w_top_ok_nx   = r_top_ok;
        w_bot_ok_nx   = r_bot_ok;
        w_eof_pend_nx = r_eof_pend;
        w_load        = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_row_done && w_rows_now == 2'd2) begin
                    w_state_nx    = S_EMIT;
                    w_load        = 1'b1;
                    w_ech_nx      = '0;
                    w_ecol_nx     = '0;
                    w_bot_bank_nx = r_ptr;
                    w_ctr_bank_nx = dec3(r_ptr);
                    w_top_bank_nx = inc3(r_ptr);
                    w_top_ok_nx   = (w_rows_prev == 2'd2);
                    w_bot_ok_nx   = 1'b1;
                    w_eof_pend_nx = row_eof_in;
                end else if (w_row_done && row_eof_in) begin
                    w_state_nx    = S_FLUSH;
                    w_load        = 1'b1;
                    w_ech_nx      = '0;
                    w_ecol_nx     = '0;
                    w_ctr_bank_nx = r_ptr;
                    w_top_ok_nx   = 1'b0;
                    w_bot_ok_nx   = 1'b0;
                end
            end
            S_EMIT, S_FLUSH: begin
                if (w_hs) begin
                    if (!w_ph_last) begin
                        w_load = 1'b1;
                        if (r_ecol == XW'(ROW_LEN-1)) begin
                            w_ecol_nx = '0;
                            w_ech_nx  = r_ech + CW'(1);
                        end else begin
                            w_ecol_nx = r_ecol + XW'(1);
                        end
                    end else if (r_state == S_EMIT && r_eof_pend) begin
                        // Last row of the frame becomes centre; its successor is padding.
                        w_state_nx    = S_FLUSH;
                        w_load        = 1'b1;
                        w_ech_nx      = '0;
                        w_ecol_nx     = '0;
                        w_top_bank_nx = r_ctr_bank;
                        w_ctr_bank_nx = r_bot_bank;
                        w_top_ok_nx   = 1'b1;
                        w_bot_ok_nx   = 1'b0;
                        w_eof_pend_nx = 1'b0;
                    end else begin
                        w_state_nx = S_FILL;
                    end
                end
            end
            default: w_state_nx = S_FILL;
        endcase
    end

    assign w_last_nx = (w_ech_nx == CW'(CH-1)) && (w_ecol_nx == XW'(ROW_LEN-1));
    assign w_win = {triplet(r_mem[w_top_bank_nx][w_ech_nx], w_top_ok_nx, w_ecol_nx),
                    triplet(r_mem[w_ctr_bank_nx][w_ech_nx], 1'b1,        w_ecol_nx),
                    triplet(r_mem[w_bot_bank_nx][w_ech_nx], w_bot_ok_nx, w_ecol_nx)};

    // Channel 0 of the completing row was written at least one beat earlier (CH >= 2).
    always_ff @(posedge clk_in) begin
        if (w_beat) r_mem[r_ptr][w_idx] <= row_in;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state    <= S_FILL;
            r_cnt      <= '0;
            r_ptr      <= 2'd0;
            r_rows     <= 2'd0;
            r_eof_pend <= 1'b0;
            r_top_bank <= 2'd0;
            r_ctr_bank <= 2'd0;
            r_bot_bank <= 2'd0;
            r_top_ok   <= 1'b0;
            r_bot_ok   <= 1'b0;
            r_ech      <= '0;
            r_ecol     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_eof_pend <= w_eof_pend_nx;
            r_top_bank <= w_top_bank_nx;
            r_ctr_bank <= w_ctr_bank_nx;
            r_bot_bank <= w_bot_bank_nx;
            r_top_ok   <= w_top_ok_nx;
            r_bot_ok   <= w_bot_ok_nx;
            r_ech      <= w_ech_nx;
            r_ecol     <= w_ecol_nx;
            if (w_beat) begin
                if (w_row_done) begin
                    r_cnt  <= '0;
                    r_ptr  <= inc3(r_ptr);
                    r_rows <= w_rows_now;
                end else begin
                    r_cnt  <= w_idx + CW'(1);
                    r_rows <= w_rows_prev;
                end
            end
            if (r_state == S_FLUSH && w_hs && w_ph_last) r_rows <= 2'd0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_win   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_eof   <= 1'b0;
        end else if (w_load) begin
            r_win   <= w_win;
            r_valid <= 1'b1;
            r_last  <= w_last_nx;
            r_eof   <= w_last_nx && (w_state_nx == S_FLUSH);
        end else if (w_hs) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_eof   <= 1'b0;
        end
    end

    assign win_out       = r_win;
    assign win_valid_out = r_valid;
    assign win_last_out  = r_last;
    assign win_eof_out   = r_eof;
endmodule

// File: tb/tb_sign_line_buffer.sv
// Bench for sign_line_buffer: whole-frame window model feeding an expected queue, directed and random frames.
module tb_sign_line_buffer;
    localparam int ROW_LEN = 10;
    localparam int CH      = 64;
`ifdef PAD_ONE_EN
    localparam logic PAD = 1'b1;
`else
    localparam logic PAD = 1'b0;
`endif

    logic               clk_in, rst_in;
    logic [ROW_LEN-1:0] row_in;
    logic               row_valid_in, row_ready_out, row_sof_in, row_eof_in;
    logic [8:0]         win_out;
    logic               win_valid_out, win_ready_in, win_last_out, win_eof_out;

    int checks = 0;
    int errors = 0;
    int n_win  = 0;
    int ready_mode = 0;
    logic [ROW_LEN-1:0] img [0:3][0:CH-1];
    logic [10:0] exp_q[$];
    logic [8:0]  rx_log [0:2047];
    logic        stall_held = 1'b0;
    logic [10:0] held;

    sign_line_buffer #(.ROW_LEN(ROW_LEN), .CH(CH)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .row_in(row_in), .row_valid_in(row_valid_in), .row_ready_out(row_ready_out),
        .row_sof_in(row_sof_in), .row_eof_in(row_eof_in),
        .win_out(win_out), .win_valid_out(win_valid_out), .win_ready_in(win_ready_in),
        .win_last_out(win_last_out), .win_eof_out(win_eof_out)
    );

    // clock / reset
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // consumer ready driver: 0 always, 1 random, 2 repeating 1,0,0,1
    initial begin
        int k = 0;
        win_ready_in = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            case (ready_mode)
                1:       win_ready_in = 1'($urandom_range(0, 1));
                2:       win_ready_in = (k % 4 == 0) || (k % 4 == 3);
                default: win_ready_in = 1'b1;
            endcase
            k++;
        end
    end

    // scoreboard monitor, sampled on the falling edge
    initial begin
        logic [10:0] obs, e;
        forever begin
            @(negedge clk_in);
            obs = {win_eof_out, win_last_out, win_out};
            if (rst_in && win_valid_out) begin
                chk("row_ready_during_emit", 32'(row_ready_out), 32'd0);
                if (stall_held) chk("stall_hold", 32'(obs), 32'(held));
                if (win_ready_in) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_window", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("window", 32'(obs), 32'(e));
                    end
                    if (n_win < 2048) rx_log[n_win] = win_out;
                    n_win++;
                    stall_held = 1'b0;
                end else begin
                    held = obs;
                    stall_held = 1'b1;
                end
            end else begin
                stall_held = 1'b0;
            end
        end
    end

    // Reference: every centre row y, channel-major, column-minor; out-of-range reads as PAD.
    task automatic build_expected(input int n);
        for (int y = 0; y < n; y++)
            for (int c = 0; c < CH; c++)
                for (int x = 0; x < ROW_LEN; x++) begin
                    logic [8:0] w = '0;
                    logic last, eof;
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) begin
                            int r = y + dy;
                            int cc = x + dx;
                            logic b;
                            logic [ROW_LEN-1:0] t;
                            if (r < 0 || r >= n || cc < 0 || cc >= ROW_LEN) b = PAD;
                            else begin
                                t = img[r][c] >> (ROW_LEN - 1 - cc);
                                b = t[0];
                            end
                            w = {w[7:0], b};
                        end
                    last = (c == CH - 1) && (x == ROW_LEN - 1);
                    eof  = last && (y == n - 1);
                    exp_q.push_back({eof, last, w});
                end
    endtask

    // driver tasks
    task automatic drive_beat(input logic [ROW_LEN-1:0] d, input logic sof, input logic eof);
        int t = 0;
        row_in = d; row_sof_in = sof; row_eof_in = eof; row_valid_in = 1'b1;
        while (!row_ready_out && t < 5000) begin
            @(posedge clk_in); #1; t++;
        end
        if (!row_ready_out) chk("beat_accept_timeout", 32'd0, 32'd1);
        @(posedge clk_in); #1;
        row_valid_in = 1'b0; row_sof_in = 1'b0; row_eof_in = 1'b0;
    endtask

    task automatic send_rows(input int first, input int last_row, input int n);
        for (int r = first; r <= last_row; r++)
            for (int c = 0; c < CH; c++)
                drive_beat(img[r][c], (r == 0) && (c == 0), (r == n - 1) && (c == CH - 1));
    endtask

    task automatic rand_img(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < CH; c++) img[r][c] = ROW_LEN'($urandom);
    endtask

    task automatic run_frame(input string tag, input int n);
        int t = 0;
        n_win = 0;
        build_expected(n);
        send_rows(0, n - 1, n);
        while (exp_q.size() != 0 && t < 20000) begin @(posedge clk_in); t++; end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_in);
        #1;
        chk({tag, "_valid_dropped"}, 32'(win_valid_out), 32'd0);
        chk({tag, "_win_count"}, 32'(n_win), 32'(n * CH * ROW_LEN));
    endtask

    initial begin
        int t;
        rst_in = 1'b0; row_valid_in = 1'b0; row_sof_in = 1'b0; row_eof_in = 1'b0; row_in = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_valid", 32'(win_valid_out), 32'd0);
        chk("reset_win", 32'(win_out), 32'd0);
        chk("reset_last", 32'(win_last_out), 32'd0);
        chk("reset_eof", 32'(win_eof_out), 32'd0);
        chk("reset_row_ready", 32'(row_ready_out), 32'd1);
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        for (int c = 0; c < CH; c++) img[0][c] = '0;
        img[0][0] = 10'h3FF;
        run_frame("one_row", 1);
`ifndef PAD_ONE_EN
        chk("one_row_ch0_col0", 32'(rx_log[0]), 32'(9'b000011000));
        chk("one_row_ch0_col5", 32'(rx_log[5]), 32'(9'b000111000));
        chk("one_row_ch1_col0", 32'(rx_log[10]), 32'd0);
`endif

        for (int c = 0; c < CH; c++) begin
            img[0][c] = 10'h200; img[1][c] = 10'h100; img[2][c] = 10'h080;
        end
        run_frame("three_row", 3);
`ifndef PAD_ONE_EN
        chk("three_row_r1_col1", 32'(rx_log[641]), 32'(9'b100010001));
`endif

        ready_mode = 2;
        rand_img(2);
        run_frame("backpressure", 2);
        ready_mode = 0;

        for (int c = 0; c < 17; c++) drive_beat(ROW_LEN'($urandom), c == 0, 1'b0);
        rand_img(2);
        run_frame("sof_restart", 2);

        rand_img(3);
        n_win = 0;
        build_expected(3);
        send_rows(0, 1, 3);
        t = 0;
        while (n_win < 100 && t < 5000) begin @(posedge clk_in); t++; end
        chk("reached_window_100", 32'(n_win >= 100), 32'd1);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        chk("midreset_valid", 32'(win_valid_out), 32'd0);
        chk("midreset_row_ready", 32'(row_ready_out), 32'd1);
        chk("midreset_win", 32'(win_out), 32'd0);
        exp_q.delete();
        rand_img(1);
        run_frame("after_reset", 1);

        for (int c = 0; c < CH; c++) img[0][c] = '0;
        run_frame("zero_row", 1);
`ifdef PAD_ONE_EN
        chk("pad_one_col0", 32'(rx_log[0]), 32'(9'b111100111));
        chk("pad_one_col4", 32'(rx_log[4]), 32'(9'b111000111));
        chk("pad_one_col9", 32'(rx_log[9]), 32'(9'b111001111));
`else
        chk("zero_row_col0", 32'(rx_log[0]), 32'd0);
`endif

        ready_mode = 1;
        for (int f = 0; f < 4; f++) begin
            int n = $urandom_range(1, 3);
            rand_img(n);
            run_frame("random_frame", n);
        end
        ready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
